// File: rtl/cuppa_trig_gen_pkg.sv
// ============================================================================
// Module      : cuppa_trig_gen_pkg
// Description : Shared constants and state type for the CUPPA trigger generator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cuppa_trig_gen_pkg;

    localparam int c_TRIG_BUNDLE_W = 18;
    localparam int c_THRESH_W      = 12;

    localparam int c_BIT_ET        = 0;
    localparam int c_BIT_GT        = 1;
    localparam int c_BIT_LT        = 2;
    localparam int c_BIT_RUN       = 3;
    localparam int c_BIT_THRESH_LO = 4;
    localparam int c_BIT_THRESH_HI = 15;
    localparam int c_BIT_THRESH_EN = 16;
    localparam int c_BIT_EXT_EN    = 17;

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_ARMED   = 2'd1;
    localparam logic [1:0] c_ST_HOLDOFF = 2'd2;

    localparam int c_SRC_THRESH = 0;
    localparam int c_SRC_EXT    = 1;

    typedef enum logic [1:0] {
        ST_IDLE    = c_ST_IDLE,
        ST_ARMED   = c_ST_ARMED,
        ST_HOLDOFF = c_ST_HOLDOFF
    } trig_state_e;

endpackage

`default_nettype wire

// File: rtl/cuppa_trig_gen_fan_out.sv
// ============================================================================
// Module      : cuppa_trig_bundle_fan_out
// Description : Splits the packed trigger configuration bundle into fields.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cuppa_trig_bundle_fan_out
    import cuppa_trig_gen_pkg::*;
(
    input  logic [c_TRIG_BUNDLE_W-1:0] i_bundle,
    output logic                       o_et,
    output logic                       o_gt,
    output logic                       o_lt,
    output logic                       o_run,
    output logic [c_THRESH_W-1:0]      o_thresh,
    output logic                       o_thresh_trig_en,
    output logic                       o_ext_trig_en
);

    assign o_et             = i_bundle[c_BIT_ET];
    assign o_gt             = i_bundle[c_BIT_GT];
    assign o_lt             = i_bundle[c_BIT_LT];
    assign o_run            = i_bundle[c_BIT_RUN];
    assign o_thresh         = i_bundle[c_BIT_THRESH_HI:c_BIT_THRESH_LO];
    assign o_thresh_trig_en = i_bundle[c_BIT_THRESH_EN];
    assign o_ext_trig_en    = i_bundle[c_BIT_EXT_EN];

endmodule

`default_nettype wire

// File: rtl/cuppa_trig_gen.sv
// ============================================================================
// Module      : cuppa_trig_gen
// Description : Threshold / external trigger generator with arming, holdoff
//               and a saturating trigger counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cuppa_trig_gen
    import cuppa_trig_gen_pkg::*;
#(
    parameter int HOLDOFF     = 16,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [c_TRIG_BUNDLE_W-1:0] bundle,
    input  logic [c_THRESH_W-1:0]      adc_data,
    input  logic                       adc_valid,
    input  logic                       ext_trig,
    input  logic                       cnt_clr,
    output logic                       trig,
    output logic [1:0]                 trig_src,
    output logic                       armed,
    output logic [CNT_W-1:0]           trig_cnt
);

    localparam int c_HO_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [c_HO_W-1:0] c_HO_LOAD = c_HO_W'(HOLDOFF - 1);

    logic                  w_et;
    logic                  w_gt;
    logic                  w_lt;
    logic                  w_run;
    logic [c_THRESH_W-1:0] w_thresh;
    logic                  w_thresh_en;
    logic                  w_ext_en;

    cuppa_trig_bundle_fan_out u_fan_out (
        .i_bundle         (bundle),
        .o_et             (w_et),
        .o_gt             (w_gt),
        .o_lt             (w_lt),
        .o_run            (w_run),
        .o_thresh         (w_thresh),
        .o_thresh_trig_en (w_thresh_en),
        .o_ext_trig_en    (w_ext_en)
    );

    trig_state_e             r_state;
    trig_state_e             w_next_state;
    logic [c_HO_W-1:0]       r_ho_cnt;
    logic [SYNC_STAGES-1:0]  r_sync;
    logic                    r_sync_d;
    logic                    r_prev_cond;
    logic                    r_trig;
    logic [1:0]              r_trig_src;
    logic [CNT_W-1:0]        r_trig_cnt;

    logic                    w_cond;
    logic                    w_thr_ev;
    logic                    w_ext_ev;
    logic                    w_fire;
    logic                    w_enter_armed;

    assign w_cond = (w_et & (adc_data == w_thresh)) |
                    (w_gt & (adc_data >  w_thresh)) |
                    (w_lt & (adc_data <  w_thresh));

    // Edge-qualified so a sustained condition gives one event per crossing
    assign w_thr_ev = adc_valid & w_thresh_en & w_cond & ~r_prev_cond;
    assign w_ext_ev = w_ext_en & r_sync[SYNC_STAGES-1] & ~r_sync_d;

    assign w_fire        = (r_state == ST_ARMED) & w_run & (w_thr_ev | w_ext_ev);
    assign w_enter_armed = (r_state != ST_ARMED) & (w_next_state == ST_ARMED);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_run) w_next_state = ST_ARMED;
            end
            ST_ARMED: begin
                if (!w_run)      w_next_state = ST_IDLE;
                else if (w_fire) w_next_state = ST_HOLDOFF;
            end
            ST_HOLDOFF: begin
                if (!w_run)               w_next_state = ST_IDLE;
                else if (r_ho_cnt == '0)  w_next_state = ST_ARMED;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next_state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ho_cnt <= '0;
        end else if (!w_run) begin
            r_ho_cnt <= '0;
        end else if (w_fire) begin
            r_ho_cnt <= c_HO_LOAD;
        end else if ((r_state == ST_HOLDOFF) && (r_ho_cnt != '0)) begin
            r_ho_cnt <= r_ho_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync   <= '0;
            r_sync_d <= 1'b0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], ext_trig};
            r_sync_d <= r_sync[SYNC_STAGES-1];
        end
    end

    // Forcing prev_cond on arming stops an already-true condition from firing
    always_ff @(posedge clk) begin
        if (rst)                r_prev_cond <= 1'b1;
        else if (w_enter_armed) r_prev_cond <= 1'b1;
        else if (adc_valid)     r_prev_cond <= w_cond;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_trig     <= 1'b0;
            r_trig_src <= 2'b00;
        end else begin
            r_trig                   <= w_fire;
            r_trig_src[c_SRC_THRESH] <= w_fire & w_thr_ev;
            r_trig_src[c_SRC_EXT]    <= w_fire & w_ext_ev;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_trig_cnt <= '0;
        end else if (cnt_clr) begin
            r_trig_cnt <= '0;
        end else if (w_fire && (r_trig_cnt != {CNT_W{1'b1}})) begin
            r_trig_cnt <= r_trig_cnt + 1'b1;
        end
    end

    assign trig     = r_trig;
    assign trig_src = r_trig_src;
    assign armed    = (r_state == ST_ARMED);
    assign trig_cnt = r_trig_cnt;

endmodule

`default_nettype wire

// File: tb/tb_cuppa_trig_gen.sv
// ============================================================================
// Module      : tb_cuppa_trig_gen
// Description : Directed self-checking bench for cuppa_trig_gen.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cuppa_trig_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [17:0] bundle;
    logic [11:0] adc_data;
    logic        adc_valid;
    logic        ext_trig;
    logic        cnt_clr;
    logic        trig;
    logic [1:0]  trig_src;
    logic        armed;
    logic [15:0] trig_cnt;

    logic [17:0] bundle2;
    logic        ext_trig2;
    logic        trig2;
    logic [1:0]  trig_src2;
    logic        armed2;
    logic [3:0]  trig_cnt2;
    logic [11:0] adc_zero = 12'h000;
    logic        low = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cuppa_trig_gen #(.HOLDOFF(16), .CNT_W(16), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .bundle(bundle), .adc_data(adc_data),
        .adc_valid(adc_valid), .ext_trig(ext_trig), .cnt_clr(cnt_clr),
        .trig(trig), .trig_src(trig_src), .armed(armed), .trig_cnt(trig_cnt)
    );

    cuppa_trig_gen #(.HOLDOFF(2), .CNT_W(4), .SYNC_STAGES(2)) dut_sat (
        .clk(clk), .rst(rst), .bundle(bundle2), .adc_data(adc_zero),
        .adc_valid(low), .ext_trig(ext_trig2), .cnt_clr(low),
        .trig(trig2), .trig_src(trig_src2), .armed(armed2), .trig_cnt(trig_cnt2)
    );

    function automatic logic [17:0] mkb(input logic et, input logic gt, input logic lt,
                                        input logic run, input logic [11:0] th,
                                        input logic ten, input logic een);
        return {een, ten, th, run, lt, gt, et};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; bundle = '0; adc_data = '0; adc_valid = 1'b0;
        ext_trig = 1'b0; cnt_clr = 1'b0; bundle2 = '0; ext_trig2 = 1'b0;
        step(); step(); step();
        chk("rst_trig", trig, 0);
        chk("rst_src", trig_src, 0);
        chk("rst_armed", armed, 0);
        chk("rst_cnt", trig_cnt, 0);

        // Basic threshold crossing
        rst = 1'b0;
        bundle = mkb(0, 1, 0, 1, 12'h800, 1, 0);
        step();
        chk("t1_armed", armed, 1);
        adc_valid = 1'b1;
        adc_data = 12'h7FE; step(); chk("t1_7fe", trig, 0);
        adc_data = 12'h7FF; step(); chk("t1_7ff", trig, 0);
        adc_data = 12'h800; step(); chk("t1_800", trig, 0);
        adc_data = 12'h801; step();
        chk("t1_trig", trig, 1);
        chk("t1_src", trig_src, 2'b01);
        chk("t1_cnt", trig_cnt, 1);
        adc_data = 12'h900;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("t1_no_retrig", trig, 0);
        end
        chk("t1_rearmed", armed, 1);
        chk("t1_cnt_hold", trig_cnt, 1);

        // Arm while condition already true
        bundle = mkb(0, 1, 0, 0, 12'h800, 1, 0);
        step();
        chk("t2_idle", armed, 0);
        adc_data = 12'hA00;
        bundle = mkb(0, 1, 0, 1, 12'h800, 1, 0);
        step(); step(); step();
        chk("t2_armed", armed, 1);
        chk("t2_no_trig", trig, 0);
        adc_data = 12'h100; step(); chk("t2_low", trig, 0);
        adc_data = 12'hA00; step();
        chk("t2_trig", trig, 1);
        chk("t2_cnt", trig_cnt, 2);

        // External trigger and holdoff; loop index is the cycle number
        bundle = mkb(0, 0, 0, 0, 12'h000, 0, 1);
        adc_valid = 1'b0;
        cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
        chk("t3_clr", trig_cnt, 0);
        bundle = mkb(0, 0, 0, 1, 12'h000, 0, 1);
        step(); step();
        chk("t3_armed", armed, 1);
        for (int c = 10; c < 50; c++) begin
            ext_trig = ((c >= 10) && (c < 15)) || ((c >= 20) && (c < 25)) ||
                       ((c >= 40) && (c < 45));
            step();
            chk($sformatf("t3_trig_c%0d", c + 1), trig, ((c + 1 == 13) || (c + 1 == 43)) ? 1 : 0);
            if (c + 1 == 13) begin
                chk("t3_src1", trig_src, 2'b10);
                chk("t3_cnt1", trig_cnt, 1);
            end
            if (c + 1 == 43) begin
                chk("t3_src2", trig_src, 2'b10);
                chk("t3_cnt2", trig_cnt, 2);
            end
        end
        ext_trig = 1'b0;

        // Simultaneous threshold and external events
        for (int i = 0; i < 10; i++) step();
        chk("t4_armed", armed, 1);
        bundle = mkb(0, 1, 0, 1, 12'h800, 1, 1);
        adc_valid = 1'b1; adc_data = 12'h100;
        step();
        chk("t4_idle_trig", trig, 0);
        ext_trig = 1'b1; step();
        ext_trig = 1'b0; step();
        adc_data = 12'hA00; step();
        chk("t4_trig", trig, 1);
        chk("t4_src", trig_src, 2'b11);
        chk("t4_cnt", trig_cnt, 3);

        // Mid-holdoff disarm and re-arm
        adc_valid = 1'b0;
        step(); step(); step();
        chk("t5_holdoff", armed, 0);
        bundle = mkb(0, 1, 0, 0, 12'h800, 1, 1);
        step(); chk("t5_idle", armed, 0);
        step(); step();
        chk("t5_idle2", armed, 0);
        chk("t5_no_trig", trig, 0);
        bundle = mkb(0, 1, 0, 1, 12'h800, 1, 1);
        step();
        chk("t5_rearm", armed, 1);
        chk("t5_cnt", trig_cnt, 3);

        // Clear coincident with a trigger
        ext_trig = 1'b1; step();
        ext_trig = 1'b0; step();
        cnt_clr = 1'b1; step();
        chk("t5_clr_trig", trig, 1);
        chk("t5_clr_src", trig_src, 2'b10);
        step();
        chk("t5_clr_cnt", trig_cnt, 0);
        cnt_clr = 1'b0;

        // Saturation on the 4-bit counter instance
        bundle2 = mkb(0, 0, 0, 1, 12'h000, 0, 1);
        step(); step();
        chk("t5_sat_armed", armed2, 1);
        for (int i = 0; i < 20; i++) begin
            ext_trig2 = 1'b1; step();
            ext_trig2 = 1'b0;
            for (int j = 0; j < 7; j++) step();
            chk($sformatf("t5_sat_%0d", i + 1), trig_cnt2, (i + 1 > 15) ? 15 : i + 1);
        end

        // Equality compare and reset mid-operation
        bundle = mkb(1, 0, 0, 0, 12'h123, 1, 0);
        step();
        bundle = mkb(1, 0, 0, 1, 12'h123, 1, 0);
        step(); step();
        chk("t6_armed", armed, 1);
        adc_valid = 1'b1;
        adc_data = 12'h122; step(); chk("t6_122", trig, 0);
        adc_data = 12'h123; step();
        chk("t6_trig1", trig, 1);
        chk("t6_src1", trig_src, 2'b01);
        chk("t6_cnt1", trig_cnt, 1);
        adc_data = 12'h124;
        for (int i = 0; i < 20; i++) step();
        chk("t6_no_trig_124", trig, 0);
        chk("t6_rearmed", armed, 1);
        adc_data = 12'h123; step();
        chk("t6_trig2", trig, 1);
        chk("t6_cnt2", trig_cnt, 2);
        step(); step();
        chk("t6_in_holdoff", armed, 0);
        rst = 1'b1;
        bundle = mkb(1, 0, 0, 0, 12'h123, 1, 0);
        step();
        chk("t6_rst_trig", trig, 0);
        chk("t6_rst_src", trig_src, 0);
        chk("t6_rst_armed", armed, 0);
        chk("t6_rst_cnt", trig_cnt, 0);
        step();
        rst = 1'b0;
        adc_data = 12'h122; step();
        adc_data = 12'h123; step();
        chk("t6_post_rst_trig", trig, 0);
        chk("t6_post_rst_armed", armed, 0);
        step();
        bundle = mkb(1, 0, 0, 1, 12'h123, 1, 0);
        step();
        chk("t6_rearm", armed, 1);
        chk("t6_rearm_no_trig", trig, 0);
        adc_data = 12'h122; step();
        chk("t6_rearm_122", trig, 0);
        adc_data = 12'h123; step();
        chk("t6_trig3", trig, 1);
        chk("t6_cnt3", trig_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
